// File: rtl/gate_model_bist_ctrl.sv
// rtl/gate_model_bist_ctrl.sv - LFSR/MISR BIST sequencer for a combinational gate model
module gate_model_bist_ctrl #(
    parameter int NUM_IN  = 13,
    parameter int NUM_OUT = 10,
    parameter int SETTLE  = 2,
    parameter int PAT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_W-1:0]   num_patterns,
    input  logic [NUM_IN-1:0]  seed,
    output logic [NUM_IN-1:0]  dut_in,
    input  logic [NUM_OUT-1:0] dut_out,
    output logic               busy,
    output logic               done,
    output logic [15:0]        signature,
    output logic [PAT_W-1:0]   pattern_idx
);

    localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [NUM_IN-1:0]   lfsr;
    logic [15:0]         misr;
    logic [PAT_W-1:0]    count;
    logic [PAT_W-1:0]    n_lat;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                do_load;
    logic                do_capture;
    logic                do_wait_inc;
    logic                last_vec;
    logic [NUM_IN-1:0]   lfsr_next;
    logic [15:0]         misr_next;

    assign last_vec  = (count == n_lat - PAT_W'(1));
    assign lfsr_next = {lfsr[NUM_IN-2:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
    // CRC-CCITT style feedback with the model outputs folded into the low bits
    assign misr_next = {misr[14:0], 1'b0} ^ (misr[15] ? 16'h1021 : 16'h0000) ^ 16'(dut_out);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        do_load     = 1'b0;
        do_capture  = 1'b0;
        do_wait_inc = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    do_load    = 1'b1;
                    state_next = (num_patterns == '0) ? ST_DONE : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    do_wait_inc = 1'b1;
                    if (wait_cnt == WAIT_W'(SETTLE - 1)) begin
                        state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                busy = 1'b1;
                // abort outranks the final capture, so no done pulse follows it
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    do_capture = 1'b1;
                    state_next = last_vec ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr     <= '0;
            misr     <= '0;
            count    <= '0;
            n_lat    <= '0;
            wait_cnt <= '0;
        end else if (do_load) begin
            lfsr     <= (seed == '0) ? NUM_IN'(1) : seed;
            misr     <= 16'hFFFF;
            count    <= '0;
            n_lat    <= num_patterns;
            wait_cnt <= '0;
        end else if (do_capture) begin
            misr <= misr_next;
            lfsr <= lfsr_next;
            if (!last_vec) begin
                count    <= count + PAT_W'(1);
                wait_cnt <= '0;
            end
        end else if (do_wait_inc) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    assign dut_in      = lfsr;
    assign signature   = misr;
    assign pattern_idx = count;

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// tb/tb_gate_model_bist_ctrl.sv - randomized bench with cycle-index reference model for gate_model_bist_ctrl
module tb_gate_model_bist_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] num_patterns;
    logic [12:0] seed;
    logic [12:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [15:0] pattern_idx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gate_model_bist_ctrl #(
        .NUM_IN (13),
        .NUM_OUT(10),
        .SETTLE (S),
        .PAT_W  (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_patterns(num_patterns),
        .seed        (seed),
        .dut_in      (dut_in),
        .dut_out     (dut_out),
        .busy        (busy),
        .done        (done),
        .signature   (signature),
        .pattern_idx (pattern_idx)
    );

    function automatic logic [12:0] lfsr_step(input logic [12:0] v);
        return {v[11:0], v[12] ^ v[3] ^ v[2] ^ v[0]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [9:0] d);
        return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {6'b0, d};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is a count of elapsed cycles; every (S+1)th cycle is a capture.
    bit          m_active = 0;
    bit          m_done   = 0;
    int          m_c      = 0;
    logic [15:0] m_n      = 0;
    logic [15:0] m_misr   = 0;
    logic [15:0] m_idx    = 0;
    logic [12:0] m_lfsr   = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 0;
            m_done   = 0;
            m_lfsr   = 0;
            m_misr   = 0;
            m_idx    = 0;
            m_c      = 0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 0;
            end else begin
                if (m_c % (S + 1) == S) begin
                    m_misr = misr_step(m_misr, dut_out);
                    m_lfsr = lfsr_step(m_lfsr);
                    if (m_c / (S + 1) == int'(m_n) - 1) begin
                        m_active = 0;
                        m_done   = 1;
                    end else begin
                        m_idx = m_idx + 16'd1;
                    end
                end
                m_c++;
            end
        end else if (m_done) begin
            m_done = 0;
        end else if (start) begin
            m_n    = num_patterns;
            m_lfsr = (seed == 13'd0) ? 13'd1 : seed;
            m_misr = 16'hFFFF;
            m_idx  = 0;
            m_c    = 0;
            if (num_patterns == 16'd0) m_done = 1;
            else m_active = 1;
        end
    end

    always @(negedge clk) begin
        cmp("model_busy", 32'(busy), 32'(m_active));
        cmp("model_done", 32'(done), 32'(m_done));
        cmp("model_dut_in", 32'(dut_in), 32'(m_lfsr));
        cmp("model_signature", 32'(signature), 32'(m_misr));
        cmp("model_pattern_idx", 32'(pattern_idx), 32'(m_idx));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [12:0] trace_in  [1:16];
    logic [15:0] trace_idx [1:16];

    task automatic run_fixed(input logic [12:0] sd, input logic [15:0] n, input logic [9:0] dout,
                             input bit poke, output int done_cyc, output logic [15:0] sig);
        seed         = sd;
        num_patterns = n;
        dut_out      = dout;
        abort        = 1'b0;
        start        = 1'b1;
        tick();
        start    = 1'b0;
        done_cyc = -1;
        sig      = 16'h0;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c <= 16) begin
                trace_in[c]  = dut_in;
                trace_idx[c] = pattern_idx;
            end
            if (done) begin
                done_cyc = c;
                sig      = signature;
            end
            if (poke && c == 4) begin
                start        = 1'b1;
                seed         = 13'h1ABC;
                num_patterns = 16'd50;
            end else if (poke && c == 5) begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        int          dc;
        logic [15:0] sig;
        logic [12:0] exp_vec [0:3];

        rst_n        = 1'b0;
        start        = 1'b1;
        abort        = 1'b0;
        num_patterns = 16'd3;
        seed         = 13'd1;
        dut_out      = 10'd0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cmp("reset_busy", 32'(busy), 32'd0);
        cmp("reset_done", 32'(done), 32'd0);
        cmp("reset_dut_in", 32'(dut_in), 32'd0);
        cmp("reset_signature", 32'(signature), 32'd0);
        cmp("reset_pattern_idx", 32'(pattern_idx), 32'd0);
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        tick();

        exp_vec[0] = 13'h0001;
        exp_vec[1] = 13'h0003;
        exp_vec[2] = 13'h0007;
        exp_vec[3] = 13'h000E;
        run_fixed(13'd1, 16'd4, 10'd0, 1'b0, dc, sig);
        cmp("lfsr_done_cycle", 32'(dc), 32'd13);
        for (int c = 1; c <= 12; c++) begin
            cmp("lfsr_seq_dut_in", 32'(trace_in[c]), 32'(exp_vec[(c - 1) / 3]));
            cmp("lfsr_seq_idx", 32'(trace_idx[c]), 32'((c - 1) / 3));
        end

        run_fixed(13'd1, 16'd3, 10'd0, 1'b0, dc, sig);
        cmp("n3_zero_done_cycle", 32'(dc), 32'd10);
        cmp("n3_zero_signature", 32'(sig), 32'h8F1F);

        run_fixed(13'd1, 16'd1, 10'h3FF, 1'b0, dc, sig);
        cmp("n1_ones_done_cycle", 32'(dc), 32'd4);
        cmp("n1_ones_signature", 32'(sig), 32'hEC20);

        run_fixed(13'd1, 16'd0, 10'h155, 1'b0, dc, sig);
        cmp("n0_done_cycle", 32'(dc), 32'd1);
        cmp("n0_signature", 32'(sig), 32'hFFFF);

        run_fixed(13'd0, 16'd2, 10'd0, 1'b0, dc, sig);
        cmp("seed0_first_dut_in", 32'(trace_in[1]), 32'h0001);

        run_fixed(13'd5, 16'd3, 10'd0, 1'b1, dc, sig);
        cmp("start_while_busy_done_cycle", 32'(dc), 32'd10);
        cmp("start_while_busy_signature", 32'(sig), 32'h8F1F);

        // abort during the capture cycle of the last vector (N=2 -> capture in cycle 6)
        seed         = 13'd1;
        num_patterns = 16'd2;
        dut_out      = 10'd0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        @(negedge clk);
        cmp("abort_pre_busy", 32'(busy), 32'd1);
        cmp("abort_pre_idx", 32'(pattern_idx), 32'd1);
        tick();
        abort = 1'b0;
        @(negedge clk);
        cmp("abort_busy", 32'(busy), 32'd0);
        cmp("abort_done", 32'(done), 32'd0);
        cmp("abort_signature", 32'(signature), 32'hEFDF);
        cmp("abort_dut_in", 32'(dut_in), 32'h0003);
        for (int i = 0; i < 6; i++) begin
            tick();
            @(negedge clk);
            cmp("abort_no_done", 32'(done), 32'd0);
        end
        tick();

        // reset in the middle of a run
        num_patterns = 16'd5;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        cmp("midreset_busy", 32'(busy), 32'd0);
        cmp("midreset_done", 32'(done), 32'd0);
        cmp("midreset_dut_in", 32'(dut_in), 32'd0);
        cmp("midreset_signature", 32'(signature), 32'd0);
        cmp("midreset_idx", 32'(pattern_idx), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            @(negedge clk);
            cmp("midreset_no_done", 32'(done), 32'd0);
        end
        tick();

        for (int i = 0; i < 3000; i++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 3) == 0);
            abort   = ($urandom_range(0, 39) == 0);
            dut_out = 10'($urandom);
            if ($urandom_range(0, 3) == 0) num_patterns = 16'($urandom_range(0, 6));
            seed = ($urandom_range(0, 7) == 0) ? 13'd0 : 13'($urandom);
            tick();
        end

        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_model_bist_ctrl.md
# gate_model_bist_ctrl

Built-in self-test sequencer for the 13-input / 10-output combinational gate models in the gate library. It drives pseudo-random input vectors from an LFSR into the gate model and waits a programmable settle time per vector. It compacts the model's outputs into a 16-bit MISR signature and reports completion with a busy/done handshake. It sits between the simulator's test harness and one gate-model instance.

## Interface
- NUM_IN, 13: gate-model input width; fixed at 13 for the LFSR taps below.
- NUM_OUT, 10: gate-model output width; must be ≤16.
- SETTLE, 2: cycles each vector is held before capture; must be ≥1.
- PAT_W, 16: width of the pattern counter.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  cancel a run in progress.
- num_patterns  in  PAT_W  number of vectors to apply; latched at start.
- seed  in  NUM_IN  initial LFSR value; latched at start; 0 is replaced by 1.
- dut_in  out  NUM_IN  vector to the gate model; equals the LFSR register.
- dut_out  in  NUM_OUT  gate-model outputs.
- busy  out  1  high while a run is active.
- done  out  1  one-cycle pulse at run completion.
- signature  out  16  MISR register; valid when done=1 and held until the next start.
- pattern_idx  out  PAT_W  index of the vector currently applied.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE, with start=1:
  - Load lfsr=seed (1 if seed==0), misr=16'hFFFF, count=0, wait=0, and latch num_patterns.
  - If the latched count is 0, go to DONE; otherwise go to SETTLE.
- SETTLE: wait++. When wait==SETTLE-1, go to CAPTURE.
- CAPTURE:
  - misr <= {misr[14:0],1'b0} ^ (misr[15] ? 16'h1021 : 0) ^ zero-extended dut_out.
  - lfsr <= {lfsr[11:0], lfsr[12]^lfsr[3]^lfsr[2]^lfsr[0]}.
  - If count==N-1, go to DONE; otherwise count++, wait=0, go to SETTLE.
- DONE: done=1, busy=0. Return to IDLE next cycle. signature keeps its value.
- busy=1 in SETTLE and CAPTURE only. done=1 in DONE only. Both outputs are Moore-decoded.
- signature is the misr register; pattern_idx is count.
- start while busy is ignored, and the latched num_patterns and seed are unaffected.
- abort=1 in SETTLE or CAPTURE: go to IDLE next cycle. No done pulse; misr/lfsr/count freeze. abort has priority over the CAPTURE→DONE transition. abort in IDLE or DONE has no effect.
- start and abort together in IDLE: start wins.
- After the final capture, lfsr has advanced one step and dut_in shows that advanced value.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, dut_in=0, signature=0, pattern_idx=0, wait=0. Reset mid-run behaves the same; no done pulse.
- start sampled at edge 0: busy=1 from cycle 1, and dut_in=seed from cycle 1.
- Each vector occupies SETTLE+1 cycles: SETTLE cycles of hold, then 1 capture cycle.
- done is high in cycle N·(SETTLE+1)+1 after the start edge. For N=0, done is high in cycle 1.
- A new start is accepted in the cycle after DONE (IDLE), giving a back-to-back run gap of one cycle.
- dut_out is sampled only in the CAPTURE cycle. The gate model is combinational, so a new vector is stable SETTLE cycles before sampling.

## Test plan
- Reset values: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, dut_in=0, signature=0, pattern_idx=0.
- LFSR sequence: seed=1, N=4, SETTLE=2 → dut_in steps through 13'h0001, 0003, 0007, 000E with each value held 3 cycles; pattern_idx goes 0..3.
- Signature with constant outputs:
  - N=3, dut_out=0: signature=16'h8F1F.
  - N=1, dut_out=10'h3FF: signature=16'hEC20.
  - N=3, SETTLE=2: done pulses exactly in cycle 10 after the start edge.
- Boundaries: N=0 → done in cycle 1 and signature=16'hFFFF. seed=0 → first dut_in=13'h0001. start asserted while busy → no effect on the run.
- Abort and mid-run reset:
  - abort in the CAPTURE cycle of the last vector → IDLE next cycle, no done pulse, busy=0.
  - rst_n=0 mid-run → reset values next cycle, no done pulse.
